// File: rtl/trace_pkg.sv
// ============================================================================
// Module   : trace_pkg
// Brief    : Shared record type and constants for the commit trace buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_pkg;

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_CW    = 32;

  // Stored stamp width; the top truncates to its own CW (CW must be <= 64).
  localparam int CYCLE_W_MAX   = 64;

  localparam logic KIND_GRF = 1'b0;
  localparam logic KIND_DM  = 1'b1;

  typedef struct packed {
    logic                   kind;
    logic [31:0]            pc;
    logic [31:0]            addr;
    logic [31:0]            data;
    logic [CYCLE_W_MAX-1:0] cycle;
  } trace_rec_t;

  function automatic logic [7:0] sat_add_u8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/trace_fifo.sv
// ============================================================================
// Module   : trace_fifo
// Brief    : Dual-push (ordered slot 0 then 1), single-pop FWFT record FIFO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_fifo
  import trace_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push0,
  input  trace_rec_t rec0,
  input  logic       push1,
  input  trace_rec_t rec1,
  input  logic       pop,
  output trace_rec_t head,
  output logic [AW:0] count,
  output logic       valid
);

  trace_rec_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic [AW-1:0]   w_wr_ptr1;

  assign w_wr_ptr1 = r_wr_ptr + AW'(1);

  // Storage carries no reset; only the pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (push0) r_mem[r_wr_ptr] <= rec0;
    if (push1) r_mem[w_wr_ptr1] <= rec1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(push0) + AW'(push1);
      if (pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count  <= r_count + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign valid = (r_count != '0);

endmodule

`default_nettype wire

// File: rtl/commit_trace_buffer.sv
// ============================================================================
// Module   : commit_trace_buffer
// Brief    : Captures W-stage GRF writes and M-stage stores as cycle-stamped
//            records and streams them out over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter  int DEPTH = DEFAULT_DEPTH,
  parameter  int CW    = DEFAULT_CW,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          grf_we,
  input  logic [31:0]   grf_pc,
  input  logic [4:0]    grf_addr,
  input  logic [31:0]   grf_wdata,
  input  logic          dm_we,
  input  logic [31:0]   dm_pc,
  input  logic [31:0]   dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_kind,
  output logic [31:0]   out_pc,
  output logic [31:0]   out_addr,
  output logic [31:0]   out_data,
  output logic [CW-1:0] out_cycle,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);

  logic [CW-1:0] r_cycle;
  logic          r_overflow;
  logic [7:0]    r_drop_cnt;

  logic          w_grf_cap;
  logic          w_dm_cap;
  logic          w_valid;
  logic          w_pop;
  logic [AW:0]   w_count;
  logic [AW+1:0] w_free;
  logic [1:0]    w_n_req;
  logic [1:0]    w_n_drop;
  logic          w_push0;
  logic          w_push1;
  trace_rec_t    w_grf_rec;
  trace_rec_t    w_dm_rec;
  trace_rec_t    w_rec0;
  trace_rec_t    w_head;
  logic          w_unused_cycle;

  assign w_grf_cap = grf_we && (grf_addr != 5'd0);
  assign w_dm_cap  = dm_we;

  always_comb begin
    w_grf_rec       = '0;
    w_grf_rec.kind  = KIND_GRF;
    w_grf_rec.pc    = grf_pc;
    w_grf_rec.addr  = {27'd0, grf_addr};
    w_grf_rec.data  = grf_wdata;
    w_grf_rec.cycle = CYCLE_W_MAX'(r_cycle);

    w_dm_rec        = '0;
    w_dm_rec.kind   = KIND_DM;
    w_dm_rec.pc     = dm_pc;
    w_dm_rec.addr   = dm_addr;
    w_dm_rec.data   = dm_wdata;
    w_dm_rec.cycle  = CYCLE_W_MAX'(r_cycle);
  end

  // The W-stage instruction is older, so GRF always takes the first slot.
  assign w_rec0 = w_grf_cap ? w_grf_rec : w_dm_rec;

  assign w_pop   = w_valid && out_ready;
  assign w_free  = (AW+2)'(DEPTH) - (AW+2)'(w_count) + (AW+2)'(w_pop);
  assign w_n_req = {1'b0, w_grf_cap} + {1'b0, w_dm_cap};

  assign w_push0  = (w_n_req != 2'd0) && (w_free != '0);
  assign w_push1  = (w_n_req == 2'd2) && (w_free >= (AW+2)'(2));
  assign w_n_drop = w_n_req - {1'b0, w_push0} - {1'b0, w_push1};

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push0 (w_push0),
    .rec0  (w_rec0),
    .push1 (w_push1),
    .rec1  (w_dm_rec),
    .pop   (w_pop),
    .head  (w_head),
    .count (w_count),
    .valid (w_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else begin
      r_cycle <= r_cycle + CW'(1);
      if (w_n_drop != 2'd0) r_overflow <= 1'b1;
      r_drop_cnt <= sat_add_u8(r_drop_cnt, w_n_drop);
    end
  end

  // Stamp bits above CW are always zero; fold them so nothing dangles.
  assign w_unused_cycle = ^w_head.cycle;

  assign out_valid = w_valid;
  assign out_kind  = w_valid & w_head.kind;
  assign out_pc    = w_valid ? w_head.pc   : 32'd0;
  assign out_addr  = w_valid ? w_head.addr : 32'd0;
  assign out_data  = w_valid ? w_head.data : 32'd0;
  assign out_cycle = w_valid ? w_head.cycle[CW-1:0] : '0;
  assign count     = w_count;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
// ============================================================================
// Module   : tb_commit_trace_buffer
// Brief    : Self-checking bench: directed scenarios plus random traffic
//            against a queue-based reference model of the commit stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int CW    = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        grf_we = 1'b0;
  logic [31:0] grf_pc = '0;
  logic [4:0]  grf_addr = '0;
  logic [31:0] grf_wdata = '0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_pc = '0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic        out_kind;
  logic [31:0] out_pc;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [CW-1:0] out_cycle;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  commit_trace_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .grf_we(grf_we), .grf_pc(grf_pc), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
    .dm_we(dm_we), .dm_pc(dm_pc), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data), .out_cycle(out_cycle),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cycle;
  } m_rec_t;

  m_rec_t      mq[$];
  logic [31:0] m_cycle = '0;
  bit          m_ovf = 1'b0;
  int          m_drop = 0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", 64'(out_valid), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    if (mq.size() != 0) begin
      chk("kind", 64'(out_kind), 64'(mq[0].kind));
      chk("pc", 64'(out_pc), 64'(mq[0].pc));
      chk("addr", 64'(out_addr), 64'(mq[0].addr));
      chk("data", 64'(out_data), 64'(mq[0].data));
      chk("cycle", 64'(out_cycle), 64'(mq[0].cycle));
    end else begin
      chk("idle_payload", {out_kind, out_pc, out_addr[30:0]} | 64'(out_data) | 64'(out_cycle), 64'd0);
    end
  endtask

  task automatic drive(input bit gwe, input logic [4:0] ga, input logic [31:0] gd,
                       input logic [31:0] gp, input bit dwe, input logic [31:0] da,
                       input logic [31:0] dd, input logic [31:0] dp, input bit rdy);
    grf_we = gwe; grf_addr = ga; grf_wdata = gd; grf_pc = gp;
    dm_we = dwe; dm_addr = da; dm_wdata = dd; dm_pc = dp;
    out_ready = rdy;
  endtask

  task automatic idle(input bit rdy);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy);
  endtask

  task automatic admit(input m_rec_t r, inout int free);
    if (free > 0) begin
      mq.push_back(r);
      free--;
    end else begin
      m_ovf = 1'b1;
      if (m_drop < 255) m_drop++;
    end
  endtask

  // Advance one clock: update the model from the current inputs, then check.
  task automatic step();
    bit     pop;
    int     free;
    m_rec_t r;
    pop  = (mq.size() != 0) && out_ready;
    free = DEPTH - mq.size() + (pop ? 1 : 0);
    if (pop) void'(mq.pop_front());
    if (grf_we && grf_addr != 5'd0) begin
      r = '{1'b0, grf_pc, {27'd0, grf_addr}, grf_wdata, m_cycle};
      admit(r, free);
    end
    if (dm_we) begin
      r = '{1'b1, dm_pc, dm_addr, dm_wdata, m_cycle};
      admit(r, free);
    end
    m_cycle = m_cycle + 32'd1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mq.delete();
    m_cycle = '0; m_ovf = 1'b0; m_drop = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    idle(1'b0);
    do_reset();
    check_outputs();

    // Single GRF write, then stall with the head held
    drive(1'b1, 5'd8, 32'h1234, 32'h3000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk("single_count", 64'(count), 64'd1);
    chk("single_data", 64'(out_data), 64'h1234);
    idle(1'b0);
    for (int i = 0; i < 5; i++) step();
    idle(1'b1);
    step();

    // Writes to $0 are invisible
    drive(1'b1, 5'd0, 32'hDEAD, 32'h3004, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk("zero_reg_count", 64'(count), 64'd0);

    // Dual capture: GRF then DM, same stamp
    drive(1'b1, 5'd3, 32'd7, 32'h3008, 1'b1, 32'h10, 32'd9, 32'h300C, 1'b0);
    step();
    chk("dual_count", 64'(count), 64'd2);
    chk("dual_first_kind", 64'(out_kind), 64'd0);
    idle(1'b1);
    step();
    chk("dual_second_kind", 64'(out_kind), 64'd1);
    step();

    // Fill to 15, then dual capture drops the DM record
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 5'(i + 1), 32'(i * 3), 32'h4000 + 32'(i * 4), 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      step();
    end
    drive(1'b1, 5'd20, 32'hAA, 32'h5000, 1'b1, 32'h20, 32'hBB, 32'h5004, 1'b0);
    step();
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd1);

    // Full with same-cycle pop: one admitted, no drop
    drive(1'b1, 5'd21, 32'hCC, 32'h5008, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    step();
    chk("full_pop_count", 64'(count), 64'd16);
    chk("full_pop_drop", 64'(drop_cnt), 64'd1);

    // Drain to 5, then asynchronous reset mid-cycle
    idle(1'b1);
    for (int i = 0; i < 11; i++) step();
    chk("pre_reset_count", 64'(count), 64'd5);
    #3;
    reset = 1'b1;
    mq.delete();
    m_cycle = '0; m_ovf = 1'b0; m_drop = 0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1'b0);
    drive(1'b1, 5'd9, 32'h55, 32'h6000, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step();
    chk("post_reset_stamp", 64'(out_cycle), 64'd0);

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5'd1, 32'(i), 32'(i), 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      step();
    end
    for (int i = 0; i < 130; i++) begin
      drive(1'b1, 5'd2, 32'(i), 32'(i), 1'b1, 32'(i), 32'(i), 32'(i), 1'b0);
      step();
    end
    chk("drop_saturated", 64'(drop_cnt), 64'd255);

    // Random traffic: fill-heavy then drain-heavy
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            32'($urandom), 32'($urandom),
            1'($urandom_range(0, 1)),
            32'($urandom), 32'($urandom), 32'($urandom),
            1'($urandom_range(0, 99) < ((i < 200) ? 30 : 80)));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
